// File: rtl/cam_msg_ctrl.sv
// Message-framing front end for a CAM: writes tagged words into CAM slots, tracks
// complete messages in a descriptor queue and runs fixed-latency searches over the head message.
module cam_msg_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DESC_DEPTH = 4,
   parameter int CAM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_sop_i,
   input  logic                  in_eop_i,
   output logic                  msg_avail_o,
   output logic [ADDR_WIDTH-1:0] msg_start_o,
   output logic [ADDR_WIDTH-1:0] msg_end_o,
   input  logic                  msg_release_i,
   input  logic                  srch_req_i,
   input  logic [DATA_WIDTH-1:0] srch_key_i,
   output logic                  srch_ack_o,
   output logic                  srch_hit_o,
   output logic [ADDR_WIDTH-1:0] srch_index_o,
   output logic                  cam_write_o,
   output logic [ADDR_WIDTH-1:0] cam_write_index_o,
   output logic [DATA_WIDTH-1:0] cam_write_data_o,
   output logic [ADDR_WIDTH-1:0] cam_start_o,
   output logic [ADDR_WIDTH-1:0] cam_end_o,
   output logic                  cam_search_o,
   output logic [DATA_WIDTH-1:0] cam_search_data_o,
   input  logic                  cam_search_valid_i,
   input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
   output logic                  full_o,
   output logic                  err_o
);

   localparam int CAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int UW        = ADDR_WIDTH + 1;
   localparam int QW        = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
   localparam int CW        = $clog2(DESC_DEPTH + 1);
   localparam int LW        = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] wr_ptr, open_start;
   logic                  open_flag;
   logic [UW-1:0]         used;
   logic [ADDR_WIDTH-1:0] desc_start [DESC_DEPTH];
   logic [ADDR_WIDTH-1:0] desc_end   [DESC_DEPTH];
   logic [QW-1:0]         head, tail;
   logic [CW-1:0]         desc_count;
   logic [DATA_WIDTH-1:0] key_q;
   logic                  hit_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [LW-1:0]         wait_cnt;

   logic                  accept, release_ok, push, err_ev, open_n, word_cnt;
   logic [ADDR_WIDTH-1:0] wr_idx, wr_ptr_n, open_start_n, push_start, head_start, head_end;
   logic [UW-1:0]         sub_partial, rel_len, used_n;

   function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
      return (p == QW'(DESC_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign accept      = in_valid_i & in_ready_o;
   assign in_ready_o  = (used < UW'(CAM_DEPTH)) && (desc_count < CW'(DESC_DEPTH));
   assign full_o      = (used == UW'(CAM_DEPTH));
   assign msg_avail_o = (desc_count != '0);
   assign head_start  = desc_start[head];
   assign head_end    = desc_end[head];
   assign msg_start_o = msg_avail_o ? head_start : '0;
   assign msg_end_o   = msg_avail_o ? head_end : '0;
   assign release_ok  = msg_release_i & msg_avail_o & (state == IDLE);
   assign rel_len     = {1'b0, head_end - head_start} + UW'(1);

   assign cam_write_o       = accept;
   assign cam_write_index_o = wr_idx;
   assign cam_write_data_o  = in_data_i;
   assign cam_search_data_o = key_q;

   always_comb begin
      wr_idx       = wr_ptr;
      wr_ptr_n     = wr_ptr;
      open_n       = open_flag;
      open_start_n = open_start;
      push         = 1'b0;
      push_start   = open_start;
      word_cnt     = 1'b0;
      sub_partial  = '0;
      err_ev       = 1'b0;
      if (accept) begin
         if (in_sop_i) begin
            // A sop inside an open message rewinds over the partial words it abandons.
            if (open_flag) begin
               wr_idx      = open_start;
               sub_partial = {1'b0, wr_ptr - open_start};
               err_ev      = 1'b1;
            end
            wr_ptr_n     = wr_idx + 1'b1;
            word_cnt     = 1'b1;
            open_start_n = wr_idx;
            push_start   = wr_idx;
            push         = in_eop_i;
            open_n       = ~in_eop_i;
         end else if (open_flag) begin
            wr_ptr_n = wr_ptr + 1'b1;
            word_cnt = 1'b1;
            push     = in_eop_i;
            open_n   = ~in_eop_i;
         end else begin
            err_ev = 1'b1;
         end
      end
      if (msg_release_i && !release_ok) err_ev = 1'b1;
      used_n = used + UW'(word_cnt) - sub_partial - (release_ok ? rel_len : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         open_start <= '0;
         open_flag  <= 1'b0;
         used       <= '0;
         head       <= '0;
         tail       <= '0;
         desc_count <= '0;
         err_o      <= 1'b0;
         for (int unsigned i = 0; i < DESC_DEPTH; i++) begin
            desc_start[i] <= '0;
            desc_end[i]   <= '0;
         end
      end else begin
         wr_ptr     <= wr_ptr_n;
         open_start <= open_start_n;
         open_flag  <= open_n;
         used       <= used_n;
         err_o      <= err_ev;
         desc_count <= desc_count + CW'(push) - CW'(release_ok);
         if (push) begin
            desc_start[tail] <= push_start;
            desc_end[tail]   <= wr_idx;
            tail             <= q_inc(tail);
         end
         if (release_ok) head <= q_inc(head);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         key_q    <= '0;
         hit_q    <= 1'b0;
         idx_q    <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == ISSUE) key_q <= srch_key_i;
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (state == WAIT && state_n == RESP) begin
            hit_q <= cam_search_valid_i;
            idx_q <= cam_search_index_i;
         end
      end
   end

   always_comb begin
      state_n      = state;
      cam_search_o = 1'b0;
      cam_start_o  = '0;
      cam_end_o    = '1;
      srch_ack_o   = 1'b0;
      srch_hit_o   = 1'b0;
      srch_index_o = '0;
      case (state)
         IDLE: begin
            if (srch_req_i && msg_avail_o && !msg_release_i) state_n = ISSUE;
         end
         ISSUE: begin
            cam_search_o = 1'b1;
            cam_start_o  = head_start;
            cam_end_o    = head_end;
            state_n      = WAIT;
         end
         WAIT: begin
            if (wait_cnt == LW'(CAM_LAT - 1)) state_n = RESP;
         end
         RESP: begin
            srch_ack_o   = 1'b1;
            srch_hit_o   = hit_q;
            srch_index_o = idx_q;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
